// File: rtl/mem_arbiter_2x1.sv
`timescale 1ns/1ps
// Two requesters share one single-port RAM. Grant is combinational; the winner alternates on conflict.
// Read data returns MEM_LATENCY cycles after acceptance. The loser of a conflict waits one cycle at most.
module mem_arbiter_2x1 #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
    } req_t;

    pri_e                   state_q, state_d;
    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic [MEM_LATENCY-1:0] tag_q, tag_d;
    logic                   pend0, pend1;
    logic                   gnt0, gnt1;
    req_t                   req0, req1, mem_req;
    logic                   out_vld, out_tag;

    always_comb begin
        pend0 = m0_read | m0_write;
        pend1 = m1_read | m1_write;
        // Nothing is forwarded while reset is held, so no RAM access can leak out.
        gnt0  = rst & pend0 & (~pend1 | (state_q == PRI0));
        gnt1  = rst & pend1 & (~pend0 | (state_q == PRI1));
    end

    always_comb begin
        req0 = '{rd: m0_read & ~m0_write, wr: m0_write, addr: m0_address, wdat: m0_writedata};
        req1 = '{rd: m1_read & ~m1_write, wr: m1_write, addr: m1_address, wdat: m1_writedata};
        mem_req = '0;
        if (gnt0) begin
            mem_req = req0;
        end else if (gnt1) begin
            mem_req = req1;
        end
    end

    assign mem_read       = mem_req.rd;
    assign mem_write      = mem_req.wr;
    assign mem_address    = mem_req.addr;
    assign mem_writedata  = mem_req.wdat;
    assign m0_waitrequest = pend0 & ~gnt0;
    assign m1_waitrequest = pend1 & ~gnt1;

    always_comb begin
        state_d = state_q;
        if (gnt0) begin
            state_d = PRI1;
        end else if (gnt1) begin
            state_d = PRI0;
        end
    end

    // Owner tag travels with each accepted read so the return is steered in acceptance order.
    always_comb begin
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = mem_req.rd;
        tag_d[0] = gnt1;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PRI0;
            vld_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
        end
    end

    assign out_vld          = vld_q[MEM_LATENCY-1];
    assign out_tag          = tag_q[MEM_LATENCY-1];
    assign m0_readdatavalid = out_vld & ~out_tag;
    assign m1_readdatavalid = out_vld & out_tag;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
`timescale 1ns/1ps
// Directed bench: three arbiters (MEM_LATENCY 1, 2, 3) share stimulus, each with its own RAM model.
module tb_mem_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [11:0] m0_address, m1_address;
    logic [15:0] m0_writedata, m1_writedata;

    logic        wr0 [3];
    logic        wr1 [3];
    logic        rdv0 [3];
    logic        rdv1 [3];
    logic        mrd [3];
    logic        mwr [3];
    logic [15:0] rdd0 [3];
    logic [15:0] rdd1 [3];
    logic [15:0] mwd [3];
    logic [15:0] mrdata [3];
    logic [11:0] madr [3];

    logic [15:0] ram [3][4096];
    logic [15:0] pipe [3][4];
    logic        ram_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter_2x1 #(.ADDR_W(12), .DATA_W(16), .MEM_LATENCY(g + 1)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .m0_read          (m0_read),
            .m0_write         (m0_write),
            .m0_address       (m0_address),
            .m0_writedata     (m0_writedata),
            .m0_waitrequest   (wr0[g]),
            .m0_readdata      (rdd0[g]),
            .m0_readdatavalid (rdv0[g]),
            .m1_read          (m1_read),
            .m1_write         (m1_write),
            .m1_address       (m1_address),
            .m1_writedata     (m1_writedata),
            .m1_waitrequest   (wr1[g]),
            .m1_readdata      (rdd1[g]),
            .m1_readdatavalid (rdv1[g]),
            .mem_address      (madr[g]),
            .mem_read         (mrd[g]),
            .mem_write        (mwr[g]),
            .mem_writedata    (mwd[g]),
            .mem_readdata     (mrdata[g])
        );
        assign mrdata[g] = pipe[g][g];
    end

    // RAM model: contents A000|addr except 0x010 = 0x1234; read data delayed by latency g+1.
    always @(posedge clk) begin
        if (ram_ready !== 1'b1) begin
            for (int g = 0; g < 3; g++) begin
                for (int a = 0; a < 4096; a++) begin
                    ram[g][a] <= (a == 16) ? 16'h1234 : (16'hA000 | 16'(a));
                end
            end
            ram_ready <= 1'b1;
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (mwr[g]) ram[g][madr[g]] <= mwd[g];
                pipe[g][0] <= ram[g][madr[g]];
                for (int s = 1; s < 4; s++) pipe[g][s] <= pipe[g][s-1];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input int d, input logic v0, input logic [15:0] e0,
                          input logic v1, input logic [15:0] e1);
        chk($sformatf("rdv0[%0d]", d), 32'(rdv0[d]), 32'(v0));
        chk($sformatf("rdd0[%0d]", d), 32'(rdd0[d]), 32'(e0));
        chk($sformatf("rdv1[%0d]", d), 32'(rdv1[d]), 32'(v1));
        chk($sformatf("rdd1[%0d]", d), 32'(rdd1[d]), 32'(e1));
    endtask

    task automatic chk_mem(input int d, input logic rd, input logic wr,
                           input logic [11:0] adr, input logic [15:0] wd);
        chk($sformatf("mem_read[%0d]", d), 32'(mrd[d]), 32'(rd));
        chk($sformatf("mem_write[%0d]", d), 32'(mwr[d]), 32'(wr));
        chk($sformatf("mem_address[%0d]", d), 32'(madr[d]), 32'(adr));
        chk($sformatf("mem_writedata[%0d]", d), 32'(mwd[d]), 32'(wd));
    endtask

    task automatic chk_wait(input int d, input logic w0, input logic w1);
        chk($sformatf("m0_waitrequest[%0d]", d), 32'(wr0[d]), 32'(w0));
        chk($sformatf("m1_waitrequest[%0d]", d), 32'(wr1[d]), 32'(w1));
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [11:0] a1, input logic [15:0] d1);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a read pending: nothing reaches the RAM, no read data.
        rst = 1'b0;
        drive(1, 0, 12'h033, 16'h0, 0, 0, 12'h0, 16'h0);
        @(negedge clk); #2;
        for (int d = 0; d < 3; d++) begin
            chk_mem(d, 0, 0, 12'h0, 16'h0);
            chk_rd(d, 0, 16'h0, 0, 16'h0);
        end
        repeat (3) @(negedge clk);

        // Both write every cycle from reset: grants m0, m1, m0, m1.
        rst = 1'b1;
        drive(0, 1, 12'h100, 16'h1111, 0, 1, 12'h101, 16'h2221); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 1); chk_mem(d, 0, 1, 12'h100, 16'h1111); end
        @(negedge clk); drive(0, 1, 12'h100, 16'h1112, 0, 1, 12'h101, 16'h2221); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 1, 0); chk_mem(d, 0, 1, 12'h101, 16'h2221); end
        @(negedge clk); drive(0, 1, 12'h100, 16'h1112, 0, 1, 12'h101, 16'h2222); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 1); chk_mem(d, 0, 1, 12'h100, 16'h1112); end
        @(negedge clk); drive(0, 1, 12'h100, 16'h1113, 0, 1, 12'h101, 16'h2222); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 1, 0); chk_mem(d, 0, 1, 12'h101, 16'h2222); end
        @(negedge clk); drive(0, 1, 12'h100, 16'h1113, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) begin
            chk_wait(d, 0, 0); chk_mem(d, 0, 1, 12'h100, 16'h1113); chk_rd(d, 0, 16'h0, 0, 16'h0);
        end
        @(negedge clk); idle(); #2;
        for (int d = 0; d < 3; d++) begin chk_mem(d, 0, 0, 12'h0, 16'h0); chk_rd(d, 0, 16'h0, 0, 16'h0); end

        // Lone m0 read of 0x010 (state PRI1, still granted).
        @(negedge clk); drive(1, 0, 12'h010, 16'h0, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 0); chk_mem(d, 1, 0, 12'h010, 16'h0); end
        @(negedge clk); idle(); #2;
        chk_rd(0, 1, 16'h1234, 0, 16'h0); chk_rd(1, 0, 16'h0, 0, 16'h0); chk_rd(2, 0, 16'h0, 0, 16'h0);
        chk_mem(0, 0, 0, 12'h0, 16'h0);
        @(negedge clk); #2;
        chk_rd(0, 0, 16'h0, 0, 16'h0); chk_rd(1, 1, 16'h1234, 0, 16'h0); chk_rd(2, 0, 16'h0, 0, 16'h0);
        @(negedge clk); #2;
        chk_rd(1, 0, 16'h0, 0, 16'h0); chk_rd(2, 1, 16'h1234, 0, 16'h0);

        // m1 read 0x020 then m0 read 0x021 back-to-back.
        @(negedge clk); drive(0, 0, 12'h0, 16'h0, 1, 0, 12'h020, 16'h0); #2;
        for (int d = 0; d < 3; d++) chk_mem(d, 1, 0, 12'h020, 16'h0);
        @(negedge clk); drive(1, 0, 12'h021, 16'h0, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) chk_mem(d, 1, 0, 12'h021, 16'h0);
        chk_rd(0, 0, 16'h0, 1, 16'hA020);
        @(negedge clk); idle(); #2;
        chk_rd(0, 1, 16'hA021, 0, 16'h0); chk_rd(1, 0, 16'h0, 1, 16'hA020); chk_rd(2, 0, 16'h0, 0, 16'h0);
        @(negedge clk); #2;
        chk_rd(0, 0, 16'h0, 0, 16'h0); chk_rd(1, 1, 16'hA021, 0, 16'h0); chk_rd(2, 0, 16'h0, 1, 16'hA020);
        @(negedge clk); #2;
        chk_rd(1, 0, 16'h0, 0, 16'h0); chk_rd(2, 1, 16'hA021, 0, 16'h0);

        // Conflicting reads of the written words; state is PRI1 so m1 goes first.
        @(negedge clk); drive(1, 0, 12'h100, 16'h0, 1, 0, 12'h101, 16'h0); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 1, 0); chk_mem(d, 1, 0, 12'h101, 16'h0); end
        @(negedge clk); drive(1, 0, 12'h100, 16'h0, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 0); chk_mem(d, 1, 0, 12'h100, 16'h0); end
        chk_rd(0, 0, 16'h0, 1, 16'h2222);
        @(negedge clk); idle(); #2;
        chk_rd(0, 1, 16'h1113, 0, 16'h0); chk_rd(1, 0, 16'h0, 1, 16'h2222);
        @(negedge clk); #2;
        chk_rd(1, 1, 16'h1113, 0, 16'h0); chk_rd(2, 0, 16'h0, 1, 16'h2222);
        @(negedge clk); #2;
        chk_rd(2, 1, 16'h1113, 0, 16'h0);

        // Read and write together act as a write.
        @(negedge clk); drive(1, 1, 12'h005, 16'hBEEF, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 0); chk_mem(d, 0, 1, 12'h005, 16'hBEEF); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); #2;
            for (int d = 0; d < 3; d++) chk_rd(d, 0, 16'h0, 0, 16'h0);
        end

        // Same-owner back-to-back reads.
        @(negedge clk); drive(0, 0, 12'h0, 16'h0, 1, 0, 12'h005, 16'h0); #2;
        for (int d = 0; d < 3; d++) chk_mem(d, 1, 0, 12'h005, 16'h0);
        @(negedge clk); drive(0, 0, 12'h0, 16'h0, 1, 0, 12'h100, 16'h0); #2;
        chk_rd(0, 0, 16'h0, 1, 16'hBEEF);
        @(negedge clk); idle(); #2;
        chk_rd(0, 0, 16'h0, 1, 16'h1113); chk_rd(1, 0, 16'h0, 1, 16'hBEEF);
        @(negedge clk); #2;
        chk_rd(1, 0, 16'h0, 1, 16'h1113); chk_rd(2, 0, 16'h0, 1, 16'hBEEF);
        @(negedge clk); #2;
        chk_rd(2, 0, 16'h0, 1, 16'h1113);

        // Reads in flight when reset hits are dropped; priority returns to PRI0.
        @(negedge clk); drive(0, 0, 12'h0, 16'h0, 1, 0, 12'h030, 16'h0); #2;
        for (int d = 0; d < 3; d++) chk_mem(d, 1, 0, 12'h030, 16'h0);
        @(negedge clk); drive(1, 0, 12'h031, 16'h0, 0, 0, 12'h0, 16'h0); #2;
        for (int d = 0; d < 3; d++) chk_mem(d, 1, 0, 12'h031, 16'h0);
        chk_rd(0, 0, 16'h0, 1, 16'hA030);
        @(negedge clk); rst = 1'b0; idle(); #2;
        for (int d = 0; d < 3; d++) begin chk_rd(d, 0, 16'h0, 0, 16'h0); chk_mem(d, 0, 0, 12'h0, 16'h0); end
        @(negedge clk); rst = 1'b1; #2;
        for (int d = 0; d < 3; d++) chk_rd(d, 0, 16'h0, 0, 16'h0);
        @(negedge clk); #2;
        for (int d = 0; d < 3; d++) chk_rd(d, 0, 16'h0, 0, 16'h0);
        @(negedge clk); drive(0, 1, 12'h040, 16'h4444, 0, 1, 12'h041, 16'h5555); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 1); chk_mem(d, 0, 1, 12'h040, 16'h4444); end
        @(negedge clk); drive(0, 0, 12'h0, 16'h0, 0, 1, 12'h041, 16'h5555); #2;
        for (int d = 0; d < 3; d++) begin chk_wait(d, 0, 0); chk_mem(d, 0, 1, 12'h041, 16'h5555); end
        @(negedge clk); idle(); #2;
        for (int d = 0; d < 3; d++) chk_rd(d, 0, 16'h0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2x1.md
MEM_ARBITER_2X1 -- requirements
Module: mem_arbiter_2x1

Interface
REQ-001 Parameter ADDR_W, default 12, address width of both requesters and memory port.
REQ-002 Parameter DATA_W, default 16, data width of both requesters and memory port.
REQ-003 Parameter MEM_LATENCY, default 1, legal 1..4, cycles from mem_read sample edge to mem_readdata valid.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 m0_read / m0_write  input  1 each  requester 0 (CPU) read / write request.
REQ-007 m0_address  input  ADDR_W  requester 0 word address.
REQ-008 m0_writedata  input  DATA_W  requester 0 write data.
REQ-009 m0_waitrequest  output  1  high: requester 0 request not accepted this cycle; hold request stable.
REQ-010 m0_readdata  output  DATA_W  read data returned to requester 0.
REQ-011 m0_readdatavalid  output  1  one-cycle pulse qualifying m0_readdata.
REQ-012 m1_read, m1_write, m1_address, m1_writedata, m1_waitrequest, m1_readdata, m1_readdatavalid: identical to REQ-006..011 for requester 1 (loader/debug).
REQ-013 mem_address  output  ADDR_W; mem_read, mem_write  output  1 each; mem_writedata  output  DATA_W: single-port RAM request.
REQ-014 mem_readdata  input  DATA_W  RAM read data, valid MEM_LATENCY cycles after read accepted.

Function
REQ-015 Requester k is pending when mk_read or mk_write is high; both high treated as write, read ignored.
REQ-016 At most one request forwarded to memory per cycle; forwarding combinational from requester inputs and registered priority state.
REQ-017 Priority FSM, states PRI0 (m0 wins conflict) and PRI1 (m1 wins conflict); reset state PRI0.
REQ-018 Only one requester pending: granted regardless of state.
REQ-019 Both pending: state holder granted; loser sees waitrequest=1.
REQ-020 Transition on each accepted request: grant to m0 -> PRI1; grant to m1 -> PRI0; no grant -> state held.
REQ-021 Granted requester: mk_waitrequest=0, mem_* driven from its inputs; non-pending requester: mk_waitrequest=0.
REQ-022 No grant: mem_read=0, mem_write=0, mem_address and mem_writedata=0.
REQ-023 Accepted read pushes owner tag into MEM_LATENCY-deep valid/tag shift register; on exit, owner's readdatavalid=1 for exactly one cycle, readdata=mem_readdata.
REQ-024 Non-owner readdata=0 and readdatavalid=0; both readdatavalid never high same cycle.
REQ-025 Back-to-back reads (alternating or same owner) return one per cycle, in acceptance order.
REQ-026 Writes produce no readdatavalid.
REQ-027 Requester held under waitrequest is served no later than the second cycle of conflict (starvation bound one cycle).

Reset
REQ-028 rst low asynchronously: FSM -> PRI0, shift register cleared, readdatavalid outputs 0, mem_read/mem_write 0 while rst low.
REQ-029 rst low mid-read: in-flight read data discarded; no readdatavalid after rst release.
REQ-030 First grant possible on first rising edge with rst high.

Verification
REQ-031 m0_read addr 0x010 alone, RAM[0x010]=0x1234, MEM_LATENCY=1 -> waitrequest0=0, mem_read=1 addr 0x010; next cycle m0_readdatavalid=1, m0_readdata=0x1234.
REQ-032 m0_write and m1_write both asserted 4 cycles from reset -> grants m0,m1,m0,m1; loser waitrequest=1 each cycle; RAM holds last write per address.
REQ-033 m1 read 0x020 then m0 read 0x021 back-to-back, MEM_LATENCY=3 -> m1_readdatavalid cycle 3, m0_readdatavalid cycle 4, correct data, never overlapping.
REQ-034 m0_read and m0_write both high, addr 0x005, data 0xBEEF -> mem_write=1, mem_read=0, no m0_readdatavalid, RAM[0x005]=0xBEEF.
REQ-035 rst pulsed low one cycle after m1 read accepted (MEM_LATENCY=2) -> no m1_readdatavalid; state PRI0; next conflict granted to m0.
REQ-036 Random concurrent traffic 10000 cycles vs reference model -> every accepted read returned once, in order, correct owner and data; max wait one cycle.
